// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: default widths, starvation limit and FSM encoding.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH   = 28;
  localparam int unsigned BLOCK_WIDTH  = 128;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned CNT_WIDTH    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both cache memory ports plus the shared main-memory port.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH  = mem_arbiter_pkg::ADDR_WIDTH,
  parameter int unsigned BLOCK_WIDTH = mem_arbiter_pkg::BLOCK_WIDTH
);

  logic                   i_mem_read;
  logic [ADDR_WIDTH-1:0]  i_mem_addr;
  logic [BLOCK_WIDTH-1:0] i_mem_rdata;
  logic                   i_mem_ready;

  logic                   d_mem_read;
  logic                   d_mem_write;
  logic [ADDR_WIDTH-1:0]  d_mem_addr;
  logic [BLOCK_WIDTH-1:0] d_mem_wdata;
  logic [BLOCK_WIDTH-1:0] d_mem_rdata;
  logic                   d_mem_ready;

  logic                   mem_read;
  logic                   mem_write;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [BLOCK_WIDTH-1:0] mem_wdata;
  logic [BLOCK_WIDTH-1:0] mem_rdata;
  logic                   mem_ready;

  // Arbiter view
  modport slave (
    input  i_mem_read, i_mem_addr,
    input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    input  mem_rdata, mem_ready,
    output i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  // Environment view: caches and memory model
  modport master (
    output i_mem_read, i_mem_addr,
    output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    output mem_rdata, mem_ready,
    input  i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_arb_starve_cnt.sv
// Saturating count of D grants taken while the instruction cache is waiting.
module arb_starve_cnt #(
  parameter int unsigned LIMIT     = mem_arbiter_pkg::STARVE_LIMIT,
  parameter int unsigned CNT_WIDTH = mem_arbiter_pkg::CNT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit_c
);

  logic [CNT_WIDTH-1:0] cnt;

  assign at_limit_c = (cnt == CNT_WIDTH'(LIMIT));

  // Clear has priority; increment holds once the limit is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit_c) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-way arbiter for the 128-bit memory port: D-cache priority, grant locked per block, I forced after a run of D grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = mem_arbiter_pkg::ADDR_WIDTH,
  parameter int unsigned BLOCK_WIDTH  = mem_arbiter_pkg::BLOCK_WIDTH,
  parameter int unsigned STARVE_LIMIT = mem_arbiter_pkg::STARVE_LIMIT,
  parameter int unsigned CNT_WIDTH    = mem_arbiter_pkg::CNT_WIDTH
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);

  arb_state_e             state;
  logic                   mem_read_q;
  logic                   mem_write_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [BLOCK_WIDTH-1:0] mem_wdata_q;

  logic dreq_c;
  logic at_limit_c;
  logic grant_i_c;
  logic grant_d_c;
  logic cnt_inc_c;
  logic cnt_clr_c;

  // Arbitration decision, only acted on while IDLE
  assign dreq_c    = bus.d_mem_read | bus.d_mem_write;
  assign grant_i_c = bus.i_mem_read & (~dreq_c | at_limit_c);
  assign grant_d_c = dreq_c & ~grant_i_c;

  assign cnt_inc_c = (state == IDLE) & grant_d_c & bus.i_mem_read;
  assign cnt_clr_c = (state == IDLE) & (grant_i_c | ~bus.i_mem_read);

  arb_starve_cnt #(
    .LIMIT     (STARVE_LIMIT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_starve_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (cnt_inc_c),
    .clr        (cnt_clr_c),
    .at_limit_c (at_limit_c)
  );

  // Grant FSM with registered memory-side strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d_c) begin
            state      <= GNT_D;
            mem_addr_q <= bus.d_mem_addr;
            if (bus.d_mem_write) begin
              mem_write_q <= 1'b1;
              mem_wdata_q <= bus.d_mem_wdata;
            end else begin
              mem_read_q  <= 1'b1;
              mem_wdata_q <= '0;
            end
          end else if (grant_i_c) begin
            state       <= GNT_I;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= bus.i_mem_addr;
            mem_wdata_q <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (bus.mem_ready) begin
            state       <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Completion goes only to the granted side; read data is a plain broadcast
  assign bus.i_mem_ready = (state == GNT_I) & bus.mem_ready;
  assign bus.d_mem_ready = (state == GNT_D) & bus.mem_ready;
  assign bus.i_mem_rdata = bus.mem_rdata;
  assign bus.d_mem_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: grant order, strobes, ready routing, starvation guard, async reset.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           is_d;
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert;
  int   n_fail;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_d, input bit wr, input logic [27:0] addr, input logic [127:0] wdata);
    exp_t e;
    e.is_d  = is_d;
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wr ? wdata : 128'h0;
    exp_q.push_back(e);
  endtask

  // Memory model: waits for a grant, checks it against the scoreboard, completes it in grant cycle lat (>=2)
  task automatic serve(input int lat, input logic [127:0] rd, input bit drop, output int waits);
    exp_t e;
    waits = 0;
    @(negedge clk);
    while (!(bus.mem_read || bus.mem_write) && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    check("grant_seen", 128'(waits < 40), 128'(1));
    if (exp_q.size() == 0) begin
      check("sb_nonempty", 128'(exp_q.size()), 128'(1));
      return;
    end
    e = exp_q.pop_front();
    check("mem_write", 128'(bus.mem_write), 128'(e.wr));
    check("mem_read", 128'(bus.mem_read), 128'(!e.wr));
    check("mem_addr", 128'(bus.mem_addr), 128'(e.addr));
    check("mem_wdata", bus.mem_wdata, e.wdata);
    repeat (lat - 2) begin
      @(negedge clk);
      check("hold_addr", 128'(bus.mem_addr), 128'(e.addr));
      check("ready_early", 128'({bus.i_mem_ready, bus.d_mem_ready}), 128'(0));
    end
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rd;
    @(negedge clk);
    check("i_ready", 128'(bus.i_mem_ready), 128'(!e.is_d));
    check("d_ready", 128'(bus.d_mem_ready), 128'(e.is_d));
    check("rdata", e.is_d ? bus.d_mem_rdata : bus.i_mem_rdata, rd);
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    if (drop) begin
      if (e.is_d) begin
        bus.d_mem_read  = 1'b0;
        bus.d_mem_write = 1'b0;
      end else begin
        bus.i_mem_read = 1'b0;
      end
    end
    @(negedge clk);
    check("idle_gap", 128'({bus.mem_read, bus.mem_write}), 128'(0));
    check("idle_addr", 128'(bus.mem_addr), 128'(0));
  endtask

  initial begin
    int w;
    int k;
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.i_mem_read  = 1'b0;
    bus.i_mem_addr  = '0;
    bus.d_mem_read  = 1'b0;
    bus.d_mem_write = 1'b0;
    bus.d_mem_addr  = '0;
    bus.d_mem_wdata = '0;
    bus.mem_rdata   = '0;
    bus.mem_ready   = 1'b0;

    // Reset values
    #1;
    check("rst_strobes", 128'({bus.mem_read, bus.mem_write}), 128'(0));
    check("rst_addr", 128'(bus.mem_addr), 128'(0));
    check("rst_wdata", bus.mem_wdata, 128'h0);
    check("rst_ready", 128'({bus.i_mem_ready, bus.d_mem_ready}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // I read alone, one-cycle request-to-strobe latency
    @(posedge clk);
    #1;
    bus.i_mem_read = 1'b1;
    bus.i_mem_addr = 28'h0000010;
    push(1'b0, 1'b0, 28'h0000010, '0);
    serve(3, a5, 1'b1, w);
    check("i_latency", 128'(w), 128'(1));

    // mem_ready while IDLE is not forwarded
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'h77;
    @(negedge clk);
    check("idle_ready", 128'({bus.i_mem_ready, bus.d_mem_ready}), 128'(0));
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("idle_strobes", 128'({bus.mem_read, bus.mem_write}), 128'(0));

    // Simultaneous I read and D write: D first, I after an IDLE cycle
    @(posedge clk);
    #1;
    bus.i_mem_read  = 1'b1;
    bus.i_mem_addr  = 28'h0000030;
    bus.d_mem_write = 1'b1;
    bus.d_mem_addr  = 28'h0000020;
    bus.d_mem_wdata = 128'h1234;
    push(1'b1, 1'b1, 28'h0000020, 128'h1234);
    push(1'b0, 1'b0, 28'h0000030, '0);
    serve(2, 128'h5555, 1'b1, w);
    check("d_latency", 128'(w), 128'(1));
    serve(3, 128'h6666, 1'b1, w);
    check("i_after_gap", 128'(w), 128'(0));

    // D read and write together: write wins
    @(posedge clk);
    #1;
    bus.d_mem_read  = 1'b1;
    bus.d_mem_write = 1'b1;
    bus.d_mem_addr  = 28'h0000024;
    bus.d_mem_wdata = 128'hBEEF;
    push(1'b1, 1'b1, 28'h0000024, 128'hBEEF);
    serve(2, 128'h0, 1'b1, w);

    // Starvation guard: 4 D, I, then counter cleared so 4 more D, then I
    @(posedge clk);
    #1;
    bus.i_mem_read = 1'b1;
    bus.i_mem_addr = 28'h0000040;
    bus.d_mem_read = 1'b1;
    bus.d_mem_addr = 28'h0000050;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) push(1'b1, 1'b0, 28'h0000050, '0);
      push(1'b0, 1'b0, 28'h0000040, '0);
    end
    k = 0;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) begin
        serve(2, 128'(k), (r == 1 && j == 3), w);
        k++;
      end
      serve(2, 128'h1F, (r == 1), w);
    end
    check("sb_drained", 128'(exp_q.size()), 128'(0));

    // Async reset during a D write abandons it silently
    @(posedge clk);
    #1;
    bus.d_mem_write = 1'b1;
    bus.d_mem_addr  = 28'h0000060;
    bus.d_mem_wdata = 128'hDEAD;
    w = 0;
    @(negedge clk);
    while (!bus.mem_write && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("pre_rst_write", 128'(bus.mem_write), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_strobes", 128'({bus.mem_read, bus.mem_write}), 128'(0));
    check("async_addr", 128'(bus.mem_addr), 128'(0));
    check("async_wdata", bus.mem_wdata, 128'h0);
    bus.d_mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 128'({bus.i_mem_ready, bus.d_mem_ready}), 128'(0));
    check("post_rst_strobes", 128'({bus.mem_read, bus.mem_write}), 128'(0));
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;

    // Fresh I read after reset shows the FSM back in IDLE
    @(posedge clk);
    #1;
    bus.i_mem_read = 1'b1;
    bus.i_mem_addr = 28'h0000070;
    push(1'b0, 1'b0, 28'h0000070, '0);
    serve(2, 128'hC0FFEE, 1'b1, w);
    check("post_rst_latency", 128'(w), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
